// File: rtl/o_upd_ctrl_if.sv
// Handshake and operand bundle between the online-softmax row-statistics sequencer and its
// neighbours. The slave modport is the sequencer; master is the surrounding datapath.
interface o_upd_ctrl_if #(
  parameter int unsigned D_W        = 16,
  parameter int unsigned TIL        = 16,
  parameter int unsigned TILE_CNT_W = 8
);
  logic                             I_START;
  logic [TILE_CNT_W-1:0]            I_NUM_TILES;
  logic                             I_STAT_VLD;
  logic                             O_STAT_RDY;
  logic [0:TIL-1][D_W-1:0]          I_LI_NEW;
  logic [0:TIL-1][D_W-1:0]          I_MI_NEW;
  logic                             O_UPD_ENA;
  logic [0:TIL-1][D_W-1:0]          O_LI_OLD;
  logic [0:TIL-1][D_W-1:0]          O_MI_OLD;
  logic [0:TIL-1][D_W-1:0]          O_LI_NEW;
  logic [0:TIL-1][D_W-1:0]          O_MI_NEW;
  logic                             I_UPD_VLD;
  logic [0:TIL-1][D_W-1:0]          I_UPD_COEF;
  logic                             O_COEF_VLD;
  logic                             I_COEF_RDY;
  logic [0:TIL-1][D_W-1:0]          O_COEF;
  logic [TILE_CNT_W-1:0]            O_TILE_IDX;
  logic                             O_BUSY;
  logic                             O_ROW_DONE;
  logic [0:TIL-1][D_W-1:0]          O_LI_FINAL;
  logic                             O_ERR;

  modport slave (
    input  I_START, I_NUM_TILES, I_STAT_VLD, I_LI_NEW, I_MI_NEW, I_UPD_VLD, I_UPD_COEF,
           I_COEF_RDY,
    output O_STAT_RDY, O_UPD_ENA, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW, O_COEF_VLD, O_COEF,
           O_TILE_IDX, O_BUSY, O_ROW_DONE, O_LI_FINAL, O_ERR
  );

  modport master (
    output I_START, I_NUM_TILES, I_STAT_VLD, I_LI_NEW, I_MI_NEW, I_UPD_VLD, I_UPD_COEF,
           I_COEF_RDY,
    input  O_STAT_RDY, O_UPD_ENA, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW, O_COEF_VLD, O_COEF,
           O_TILE_IDX, O_BUSY, O_ROW_DONE, O_LI_FINAL, O_ERR
  );
endinterface

// File: rtl/o_upd_ctrl.sv
// Row-statistics sequencer: holds running per-row max/sum for a row-block, drives the
// coefficient unit for every tile after the first and hands coefficients to the O-accumulator.
module o_upd_ctrl #(
  parameter int unsigned D_W        = 16,
  parameter int unsigned TIL        = 16,
  parameter int unsigned TILE_CNT_W = 8,
  parameter int unsigned TO_W       = 8
) (
  input  logic         I_CLK,
  input  logic         I_RST,
  o_upd_ctrl_if.slave  bus
);

  typedef logic [0:TIL-1][D_W-1:0] row_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStat,
    StUpd,
    StCoefOut,
    StDone
  } state_e;

  localparam logic [TO_W-1:0] ToMax = '1;

  state_e                state_q, state_d;
  row_t                  li_old_q, li_old_d;
  row_t                  mi_old_q, mi_old_d;
  row_t                  li_new_q, li_new_d;
  row_t                  mi_new_q, mi_new_d;
  row_t                  coef_q, coef_d;
  logic [TILE_CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= StIdle;
      li_old_q    <= '0;
      mi_old_q    <= '0;
      li_new_q    <= '0;
      mi_new_q    <= '0;
      coef_q      <= '0;
      tile_idx_q  <= '0;
      num_tiles_q <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      li_old_q    <= li_old_d;
      mi_old_q    <= mi_old_d;
      li_new_q    <= li_new_d;
      mi_new_q    <= mi_new_d;
      coef_q      <= coef_d;
      tile_idx_q  <= tile_idx_d;
      num_tiles_q <= num_tiles_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    li_old_d    = li_old_q;
    mi_old_d    = mi_old_q;
    li_new_d    = li_new_q;
    mi_new_d    = mi_new_q;
    coef_d      = coef_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.I_START) begin
          if (bus.I_NUM_TILES != '0) begin
            tile_idx_d  = '0;
            num_tiles_d = bus.I_NUM_TILES;
            err_d       = 1'b0;
            state_d     = StWaitStat;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StWaitStat: begin
        if (bus.I_STAT_VLD) begin
          li_new_d = bus.I_LI_NEW;
          mi_new_d = bus.I_MI_NEW;
          if (tile_idx_q == '0) begin
            // First tile seeds the running statistics; there is nothing to rescale yet.
            li_old_d = bus.I_LI_NEW;
            mi_old_d = bus.I_MI_NEW;
            if (num_tiles_q == TILE_CNT_W'(1)) begin
              state_d = StDone;
            end else begin
              tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
            end
          end else begin
            to_cnt_d = '0;
            state_d  = StUpd;
          end
        end
      end

      StUpd: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus.I_UPD_VLD) begin
          coef_d  = bus.I_UPD_COEF;
          state_d = StCoefOut;
        end else if (to_cnt_d == ToMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StCoefOut: begin
        if (bus.I_COEF_RDY) begin
          li_old_d = li_new_q;
          mi_old_d = mi_new_q;
          if (tile_idx_q == num_tiles_q - TILE_CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
            state_d    = StWaitStat;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.O_STAT_RDY = (state_q == StWaitStat);
  assign bus.O_UPD_ENA  = (state_q == StUpd);
  assign bus.O_COEF_VLD = (state_q == StCoefOut);
  assign bus.O_ROW_DONE = (state_q == StDone);
  assign bus.O_BUSY     = (state_q != StIdle);
  assign bus.O_LI_OLD   = li_old_q;
  assign bus.O_MI_OLD   = mi_old_q;
  assign bus.O_LI_NEW   = li_new_q;
  assign bus.O_MI_NEW   = mi_new_q;
  assign bus.O_COEF     = coef_q;
  assign bus.O_TILE_IDX = tile_idx_q;
  assign bus.O_LI_FINAL = li_old_q;
  assign bus.O_ERR      = err_q;

endmodule
